regfile_wr_arbiter: RTL and testbench

Write-port arbiter and pending-write scoreboard for the 32-entry register file. Two writeback sources (ALU and memory) share the single register-file write port; the block grants one per cycle round-robin, registers the winning write, and drives the one-hot per-register write enables. It also keeps a busy bit per register, set by decode reservations and cleared on writeback, for hazard detection upstream.

---
 rtl/regfile_wr_arbiter_pkg.sv | 19 +
 rtl/regfile_wr_arbiter_if.sv | 39 +++
 rtl/regfile_wr_decoder.sv | 18 +
 rtl/regfile_wr_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 129 ++++++++++++
 5 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Covers the arbiter, its decoder and its bus interface.
package regfile_pkg;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREG = 32;

   typedef enum logic [0:0] {
      PRI_ALU = 1'b0,
      PRI_MEM = 1'b1
   } pri_state_t;

   typedef enum logic [0:0] {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback, reservation and register-file write-port bundle.
// The arbiter uses the slave side; the pipeline uses the master side.
interface regfile_wr_arbiter_if
   import regfile_pkg::*;
();

   logic            alu_valid_i;
   logic [AW-1:0]   alu_addr_i;
   logic [DW-1:0]   alu_data_i;
   logic            alu_ready_o;
   logic            mem_valid_i;
   logic [AW-1:0]   mem_addr_i;
   logic [DW-1:0]   mem_data_i;
   logic            mem_ready_o;
   logic            rsv_valid_i;
   logic [AW-1:0]   rsv_addr_i;
   logic            flush_i;
   logic [NREG-1:0] we_o;
   logic [AW-1:0]   waddr_o;
   logic [DW-1:0]   wdata_o;
   logic [NREG-1:0] busy_o;

   modport slave (
      input  alu_valid_i, alu_addr_i, alu_data_i,
      input  mem_valid_i, mem_addr_i, mem_data_i,
      input  rsv_valid_i, rsv_addr_i, flush_i,
      output alu_ready_o, mem_ready_o,
      output we_o, waddr_o, wdata_o, busy_o
   );

   modport master (
      output alu_valid_i, alu_addr_i, alu_data_i,
      output mem_valid_i, mem_addr_i, mem_data_i,
      output rsv_valid_i, rsv_addr_i, flush_i,
      input  alu_ready_o, mem_ready_o,
      input  we_o, waddr_o, wdata_o, busy_o
   );

endinterface

// File: rtl/regfile_wr_decoder.sv
// Address to one-hot register mask with enable.
// Register 0 is hardwired, so it never produces a mask bit.
module regfile_wr_decoder
   import regfile_pkg::*;
(
   input  logic            i_en,
   input  logic [AW-1:0]   i_addr,
   output logic [NREG-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en && (i_addr != '0)) begin
         o_onehot[i_addr] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter between ALU and memory writeback for the single
// register-file write port, plus the per-register pending-write scoreboard.
module regfile_wr_arbiter
   import regfile_pkg::*;
(
   input logic                 clk_i,
   input logic                 rst_ni,
   regfile_wr_arbiter_if.slave bus
);

   pri_state_t      r_state;
   pri_state_t      w_stateNext;
   logic            w_aluGrant;
   logic            w_memGrant;
   logic            w_accept;
   src_t            w_src;
   logic [AW-1:0]   w_addr;
   logic [DW-1:0]   w_data;
   logic [NREG-1:0] w_weMask;
   logic [NREG-1:0] w_rsvMask;
   logic [NREG-1:0] r_we;
   logic [AW-1:0]   r_waddr;
   logic [DW-1:0]   r_wdata;
   logic [NREG-1:0] r_busy;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= PRI_ALU;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Grants are suppressed in reset so nothing is accepted and later dropped.
   always_comb begin
      w_stateNext = r_state;
      w_aluGrant  = 1'b0;
      w_memGrant  = 1'b0;
      w_src       = SRC_ALU;
      if (rst_ni) begin
         if (bus.alu_valid_i && bus.mem_valid_i) begin
            if (r_state == PRI_ALU) begin
               w_aluGrant = 1'b1;
            end else begin
               w_memGrant = 1'b1;
            end
         end else if (bus.alu_valid_i) begin
            w_aluGrant = 1'b1;
         end else if (bus.mem_valid_i) begin
            w_memGrant = 1'b1;
         end
      end
      if (w_aluGrant) begin
         w_stateNext = PRI_MEM;
         w_src       = SRC_ALU;
      end else if (w_memGrant) begin
         w_stateNext = PRI_ALU;
         w_src       = SRC_MEM;
      end
   end

   assign w_accept = w_aluGrant | w_memGrant;
   assign w_addr   = (w_src == SRC_MEM) ? bus.mem_addr_i : bus.alu_addr_i;
   assign w_data   = (w_src == SRC_MEM) ? bus.mem_data_i : bus.alu_data_i;

   regfile_wr_decoder u_weDecoder (
      .i_en     (w_accept),
      .i_addr   (w_addr),
      .o_onehot (w_weMask)
   );

   regfile_wr_decoder u_rsvDecoder (
      .i_en     (bus.rsv_valid_i),
      .i_addr   (bus.rsv_addr_i),
      .o_onehot (w_rsvMask)
   );

   // Set after clear so a same-cycle reservation keeps the bit; flush beats both.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_we    <= '0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_busy  <= '0;
      end else begin
         r_we <= w_weMask;
         if (w_accept) begin
            r_waddr <= w_addr;
            r_wdata <= w_data;
         end
         if (bus.flush_i) begin
            r_busy <= '0;
         end else begin
            r_busy <= (r_busy & ~w_weMask) | w_rsvMask;
         end
      end
   end

   assign bus.alu_ready_o = w_aluGrant;
   assign bus.mem_ready_o = w_memGrant;
   assign bus.we_o        = r_we;
   assign bus.waddr_o     = r_waddr;
   assign bus.wdata_o     = r_wdata;
   assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed, table-driven bench for regfile_wr_arbiter: each record gives one
// cycle of inputs, the expected same-cycle readies and the post-edge outputs.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   typedef struct packed {
      logic          aluValid;
      logic [4:0]    aluAddr;
      logic [31:0]   aluData;
      logic          memValid;
      logic [4:0]    memAddr;
      logic [31:0]   memData;
      logic          rsvValid;
      logic [4:0]    rsvAddr;
      logic          flush;
      logic          expAluRdy;
      logic          expMemRdy;
      logic [31:0]   expWe;
      logic [4:0]    expWaddr;
      logic [31:0]   expWdata;
      logic [31:0]   expBusy;
   } vec_t;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   int   passCount = 0;
   int   totalCount = 0;
   vec_t vecs [19];
   vec_t v;

   regfile_wr_arbiter_if bus ();

   regfile_wr_arbiter dut (
      .clk_i  (clk),
      .rst_ni (rstN),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t s);
      bus.alu_valid_i = s.aluValid;
      bus.alu_addr_i  = s.aluAddr;
      bus.alu_data_i  = s.aluData;
      bus.mem_valid_i = s.memValid;
      bus.mem_addr_i  = s.memAddr;
      bus.mem_data_i  = s.memData;
      bus.rsv_valid_i = s.rsvValid;
      bus.rsv_addr_i  = s.rsvAddr;
      bus.flush_i     = s.flush;
   endtask

   // Called 1 time unit after a rising edge; returns at the same phase.
   task automatic runVector(input string name, input vec_t s);
      applyStimulus(s);
      #2;
      checkOutput({name, " alu_ready"}, 32'(bus.alu_ready_o), 32'(s.expAluRdy));
      checkOutput({name, " mem_ready"}, 32'(bus.mem_ready_o), 32'(s.expMemRdy));
      @(posedge clk);
      #1;
      checkOutput({name, " we"},    bus.we_o,            s.expWe);
      checkOutput({name, " waddr"}, 32'(bus.waddr_o),    32'(s.expWaddr));
      checkOutput({name, " wdata"}, bus.wdata_o,         s.expWdata);
      checkOutput({name, " busy"},  bus.busy_o,          s.expBusy);
   endtask

   initial begin
      // aluV aluA  aluD          memV memA  memD          rsvV rsvA  fl    aRdy  mRdy  we             waddr  wdata          busy
      vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 5'd5,  32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,         5'd5,  32'hDEADBEEF, 32'h0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 5'd10, 32'hA5A5A5A5, 32'h0};
      vecs[3]  = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd2,  32'h22222222, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 5'd1,  32'h11111111, 32'h0};
      vecs[4]  = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd2,  32'h22222222, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 5'd2,  32'h22222222, 32'h0};
      vecs[5]  = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd2,  32'h22222222, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 5'd1,  32'h11111111, 32'h0};
      vecs[6]  = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd2,  32'h22222222, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 5'd2,  32'h22222222, 32'h0};
      vecs[7]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0,  32'h00001234, 32'h0};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0,         5'd0,  32'h00001234, 32'h0000_0080};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,         5'd0,  32'h00001234, 32'h0000_0080};
      vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h00000077, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 5'd7,  32'h00000077, 32'h0};
      vecs[11] = '{1'b1, 5'd7,  32'h00000078, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 5'd7,  32'h00000078, 32'h0000_0080};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0,         5'd7,  32'h00000078, 32'h0000_0088};
      vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 32'h0,         5'd7,  32'h00000078, 32'h0000_0288};
      vecs[14] = '{1'b1, 5'd9,  32'h00000099, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 5'd9,  32'h00000099, 32'h0};
      vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,         5'd9,  32'h00000099, 32'h0};
      vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h0000CCCC, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 5'd12, 32'h0000CCCC, 32'h0};
      vecs[17] = '{1'b1, 5'd3,  32'h00000031, 1'b1, 5'd3,  32'h00000032, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 5'd3,  32'h00000031, 32'h0};
      vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h00000032, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 5'd3,  32'h00000032, 32'h0};

      // Reset with traffic present: readies must stay low, outputs cleared.
      v = '{1'b1, 5'd5, 32'hFFFF0000, 1'b1, 5'd6, 32'h0000FFFF, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0};
      applyStimulus(v);
      @(posedge clk);
      #1;
      runVector("reset", v);
      rstN = 1'b1;

      for (int i = 0; i < 19; i++) begin
         runVector($sformatf("vec%0d", i), vecs[i]);
      end

      // Mid-operation reset: pending reservation and grant are discarded.
      v = '{1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 5'd1, 32'h11111111, 32'h0000_0020};
      runVector("preReset", v);
      rstN = 1'b0;
      v = '{1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0};
      runVector("midReset", v);
      rstN = 1'b1;
      v = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0};
      runVector("postResetIdle", v);
      v = '{1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 5'd1, 32'h11111111, 32'h0};
      runVector("postResetAluFirst", v);
      v = '{1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 5'd2, 32'h22222222, 32'h0};
      runVector("postResetMemNext", v);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
